// File: rtl/osc_phase_accum_pkg.sv
// Shared widths, slot-field helpers and the S0->S1 bundle for the
// time-multiplexed oscillator phase accumulator.
package osc_phase_accum_pkg;

  localparam int VOICES    = 8;
  localparam int V_OSC     = 4;
  localparam int V_WIDTH   = 3;
  localparam int O_WIDTH   = 2;
  localparam int OE_WIDTH  = 1;
  localparam int E_WIDTH   = O_WIDTH + OE_WIDTH;
  localparam int S_WIDTH   = V_WIDTH + E_WIDTH;
  localparam int A_WIDTH   = V_WIDTH + O_WIDTH;
  localparam int N_SLOT    = VOICES * V_OSC;
  localparam int ACC_WIDTH = 32;
  localparam int PH_OUT    = 16;
  localparam int INC_WIDTH = 24;

  typedef struct packed {
    logic                 act;
    logic                 zero;
    logic [S_WIDTH-1:0]   slot;
    logic [INC_WIDTH-1:0] inc;
  } s1_t;

  function automatic logic [V_WIDTH-1:0] vx_of(
    input logic [S_WIDTH-1:0] s
  );
    return s[S_WIDTH-1:E_WIDTH];
  endfunction

  function automatic logic [O_WIDTH-1:0] ox_of(
    input logic [S_WIDTH-1:0] s
  );
    return s[E_WIDTH-1:OE_WIDTH];
  endfunction

  function automatic logic [OE_WIDTH-1:0] oe_of(
    input logic [S_WIDTH-1:0] s
  );
    return s[OE_WIDTH-1:0];
  endfunction

  function automatic logic [A_WIDTH-1:0] addr_of(
    input logic [S_WIDTH-1:0] s
  );
    return {vx_of(s), ox_of(s)};
  endfunction

endpackage

// File: rtl/osc_phase_accum_phase_ram.sv
// Per-oscillator phase store: one write port, one registered read port,
// contents not reset.
module phase_ram
  import osc_phase_accum_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [A_WIDTH-1:0]   i_waddr,
  input  logic [ACC_WIDTH-1:0] i_wdata,
  input  logic [A_WIDTH-1:0]   i_raddr,
  output logic [ACC_WIDTH-1:0] o_rdata
);

  logic [ACC_WIDTH-1:0] r_mem [N_SLOT];
  logic [ACC_WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/osc_phase_accum.sv
// Time-multiplexed phase accumulator with note-on phase reset and
// per-oscillator hard sync; fixed two-cycle latency.
module osc_phase_accum
  import osc_phase_accum_pkg::*;
(
  input  logic                 sCLK_XVXOSC,
  input  logic                 iRST,
  input  logic [S_WIDTH-1:0]   xxxx,
  input  logic [INC_WIDTH-1:0] osc_pitch_val,
  input  logic                 note_on,
  input  logic [V_WIDTH-1:0]   key_voice,
  input  logic [V_OSC-1:0]     sync_en,
  output logic [PH_OUT-1:0]    phase_out,
  output logic [S_WIDTH-1:0]   phase_slot,
  output logic                 phase_valid,
  output logic                 phase_wrap
);

  logic [N_SLOT-1:0]    r_pend;
  logic [N_SLOT-1:0]    r_last_carry;
  s1_t                  r_s1;
  logic [PH_OUT-1:0]    r_out;
  logic [S_WIDTH-1:0]   r_slot;
  logic                 r_valid;
  logic                 r_wrap;

  logic [V_WIDTH-1:0]   w_vx;
  logic [O_WIDTH-1:0]   w_ox;
  logic [A_WIDTH-1:0]   w_addr;
  logic [A_WIDTH-1:0]   w_prev;
  logic [A_WIDTH-1:0]   w_s1_addr;
  logic                 w_act;
  logic                 w_note_hit;
  logic                 w_sync;
  logic                 w_zero;
  logic [N_SLOT-1:0]    w_set;
  logic [N_SLOT-1:0]    w_clr;
  logic [ACC_WIDTH-1:0] w_rdata;
  logic [ACC_WIDTH:0]   w_sum;
  logic [ACC_WIDTH-1:0] w_wval;
  logic                 w_carry;

  assign w_vx   = vx_of(xxxx);
  assign w_ox   = ox_of(xxxx);
  assign w_addr = addr_of(xxxx);
  assign w_prev = w_addr - 1'b1;
  assign w_act  = (oe_of(xxxx) == '0);

  // Reset decision is taken at S0 so a note_on in the same cycle counts.
  assign w_note_hit = note_on && (key_voice == w_vx);
  assign w_sync = (w_ox != '0) && sync_en[w_ox]
                  && r_last_carry[w_prev];
  assign w_zero = r_pend[w_addr] | w_note_hit | w_sync;

  assign w_set = note_on
    ? (N_SLOT'({V_OSC{1'b1}}) << {key_voice, {O_WIDTH{1'b0}}})
    : '0;
  assign w_clr = w_act ? (N_SLOT'(1) << w_addr) : '0;

  always_ff @(posedge sCLK_XVXOSC or posedge iRST) begin
    if (iRST) begin
      r_pend <= '1;
      r_s1   <= '0;
    end else begin
      r_pend      <= (r_pend & ~w_clr) | w_set;
      r_s1.act    <= w_act;
      r_s1.zero   <= w_zero;
      r_s1.slot   <= xxxx;
      r_s1.inc    <= osc_pitch_val;
    end
  end

  phase_ram u_ram (
    .i_clk   (sCLK_XVXOSC),
    .i_we    (r_s1.act),
    .i_waddr (w_s1_addr),
    .i_wdata (w_wval),
    .i_raddr (w_addr),
    .o_rdata (w_rdata)
  );

  assign w_s1_addr = addr_of(r_s1.slot);
  assign w_sum = {1'b0, w_rdata}
    + {{(ACC_WIDTH + 1 - INC_WIDTH){1'b0}}, r_s1.inc};
  assign w_wval  = r_s1.zero ? '0 : w_sum[ACC_WIDTH-1:0];
  assign w_carry = ~r_s1.zero & w_sum[ACC_WIDTH];

  always_ff @(posedge sCLK_XVXOSC or posedge iRST) begin
    if (iRST) begin
      r_last_carry <= '0;
      r_valid      <= 1'b0;
      r_slot       <= '0;
      r_out        <= '0;
      r_wrap       <= 1'b0;
    end else begin
      if (r_s1.act)
        r_last_carry[w_s1_addr] <= w_carry;
      r_valid <= r_s1.act;
      r_slot  <= r_s1.slot;
      r_out   <= w_wval[ACC_WIDTH-1 -: PH_OUT];
      r_wrap  <= r_s1.act & w_carry;
    end
  end

  assign phase_out   = r_out;
  assign phase_slot  = r_slot;
  assign phase_valid = r_valid;
  assign phase_wrap  = r_wrap;

endmodule

// File: tb/tb_osc_phase_accum.sv
// Scoreboard bench for osc_phase_accum: behavioural per-slot model,
// expected outputs queued at drive time and popped two cycles later.
module tb_osc_phase_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  xxxx;
  logic [23:0] inc;
  logic        note_on;
  logic [2:0]  key_voice;
  logic [3:0]  sync_en;
  logic [15:0] phase_out;
  logic [5:0]  phase_slot;
  logic        phase_valid;
  logic        phase_wrap;

  always #5 clk = ~clk;

  osc_phase_accum dut (
    .sCLK_XVXOSC   (clk),
    .iRST          (rst),
    .xxxx          (xxxx),
    .osc_pitch_val (inc),
    .note_on       (note_on),
    .key_voice     (key_voice),
    .sync_en       (sync_en),
    .phase_out     (phase_out),
    .phase_slot    (phase_slot),
    .phase_valid   (phase_valid),
    .phase_wrap    (phase_wrap)
  );

  typedef struct {
    logic        v;
    logic [5:0]  slot;
    logic [15:0] ph;
    logic        wrap;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_ph [32];
  bit          m_pend [32];
  bit          m_lc [32];
  int          total = 0;
  int          bad = 0;
  bit          cnt_en = 0;
  int          wraps0 = 0;
  int          wraps18 = 0;

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] inc_of(input int a);
    case (a)
      0:       return 24'h800000;
      1:       return 24'h100000;
      9:       return 24'hFFFFFF;
      default: return 24'h000100;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_pend[i] = 1;
      m_lc[i]   = 0;
    end
    q.delete();
  endtask

  task automatic pop_check();
    exp_t e;
    if (q.size() == 2) begin
      e = q.pop_front();
      check_eq("valid", 32'(phase_valid), 32'(e.v));
      if (e.v) begin
        check_eq("slot", 32'(phase_slot), 32'(e.slot));
        check_eq("phase", 32'(phase_out), 32'(e.ph));
        check_eq("wrap", 32'(phase_wrap), 32'(e.wrap));
        if (cnt_en && phase_wrap && phase_slot == 6'd0)
          wraps0++;
        if (cnt_en && phase_wrap && phase_slot == 6'd18)
          wraps18++;
      end
    end
  endtask

  task automatic drive_slot(input int s, input bit non,
                            input logic [2:0] kv);
    exp_t        e;
    int          a;
    int          v;
    int          o;
    bit          z;
    logic [32:0] sum;
    logic [31:0] w;
    logic        c;
    @(negedge clk);
    pop_check();
    a = s >> 1;
    v = a >> 2;
    o = a & 3;
    xxxx      = 6'(s);
    inc       = inc_of(a);
    note_on   = non;
    key_voice = kv;
    e.v = (s % 2) == 0;
    e.slot = 6'(s);
    e.ph = '0;
    e.wrap = 1'b0;
    if (e.v) begin
      z = m_pend[a] || (non && kv == 3'(v))
          || (o != 0 && sync_en[o] && m_lc[a-1]);
      sum = {1'b0, m_ph[a]} + {9'b0, inc};
      w = z ? 32'd0 : sum[31:0];
      c = z ? 1'b0 : sum[32];
      m_ph[a]   = w;
      m_lc[a]   = c;
      m_pend[a] = 0;
      e.ph   = w[31:16];
      e.wrap = c;
    end
    if (non)
      for (int k = 0; k < 4; k++)
        m_pend[kv*4 + k] = 1;
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    xxxx = 6'd1;
    inc = '0;
    note_on = 1'b0;
    key_voice = '0;
    sync_en = 4'b0010;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_valid", 32'(phase_valid), 32'd0);
    check_eq("rst_phase", 32'(phase_out), 32'd0);
    check_eq("rst_slot", 32'(phase_slot), 32'd0);
    check_eq("rst_wrap", 32'(phase_wrap), 32'd0);
    rst = 1'b0;

    cnt_en = 1;
    for (int f = 0; f < 520; f++)
      for (int s = 0; s < 64; s++)
        drive_slot(s,
                   (f == 300 && s == 50) || (f == 310 && s == 40),
                   (f == 300) ? 3'd3 : 3'd5);
    cnt_en = 0;
    check_eq("wraps_v0o0", 32'(wraps0), 32'd1);
    check_eq("wraps_v2o1", 32'(wraps18), 32'd2);

    for (int s = 0; s < 18; s++)
      drive_slot(s, 1'b0, 3'd0);
    @(negedge clk);
    check_eq("pre_rst_valid", 32'(phase_valid), 32'd1);
    pop_check();
    rst = 1'b1;
    xxxx = 6'd1;
    note_on = 1'b0;
    #1;
    check_eq("async_valid", 32'(phase_valid), 32'd0);
    check_eq("async_phase", 32'(phase_out), 32'd0);
    check_eq("async_slot", 32'(phase_slot), 32'd0);
    check_eq("async_wrap", 32'(phase_wrap), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int f = 0; f < 3; f++)
      for (int s = 0; s < 64; s++)
        drive_slot(s, 1'b0, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
